// File: rtl/mmio_pkg.sv
// Shared constants for the data-memory / MMIO stage: register addresses,
// timer control bit positions and the region decoder used by the top level.
package mmio_pkg;

    localparam logic [9:0] RAM_TOP     = 10'h0FF;
    localparam logic [9:0] ADDR_LED    = 10'h100;
    localparam logic [9:0] ADDR_SW     = 10'h104;
    localparam logic [9:0] ADDR_TLOAD  = 10'h108;
    localparam logic [9:0] ADDR_TCTRL  = 10'h10C;
    localparam logic [9:0] ADDR_TCOUNT = 10'h110;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_EXP  = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_TLOAD,
        SEL_TCTRL,
        SEL_TCOUNT
    } sel_e;

    // Map a word offset (byte address bits [9:2]) onto the target it selects.
    function automatic sel_e decode(input logic [7:0] word);
        logic [9:0] byte_addr;
        byte_addr = {word, 2'b00};
        if (byte_addr <= RAM_TOP)          return SEL_RAM;
        else if (byte_addr == ADDR_LED)    return SEL_LED;
        else if (byte_addr == ADDR_SW)     return SEL_SW;
        else if (byte_addr == ADDR_TLOAD)  return SEL_TLOAD;
        else if (byte_addr == ADDR_TCTRL)  return SEL_TCTRL;
        else if (byte_addr == ADDR_TCOUNT) return SEL_TCOUNT;
        else                               return SEL_NONE;
    endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// Mem-stage bus between the core and the data-memory / MMIO stage.
interface dmem_mmio_if;
    logic        MemWriteMem;
    logic [31:0] ALUOutMem;
    logic [31:0] WriteDataMem;
    logic [31:0] ReadDataMem;

    modport master (output MemWriteMem, output ALUOutMem, output WriteDataMem,
                    input  ReadDataMem);
    modport slave  (input  MemWriteMem, input  ALUOutMem, input  WriteDataMem,
                    output ReadDataMem);
endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a stability counter; the stable output
// only follows the synchronized input after DEB_CYCLES consecutive cycles
// of disagreement.
module sw_debounce #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [WIDTH-1:0] sync1_q, sync2_q, stable_q, stable_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Counter runs only while the synchronized value disagrees with stable.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, stability counter and accepted value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sw_o = stable_q;

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus LED, switch and timer registers behind one decoder.
// Loads are combinational; stores land on the rising edge.
module dmem_mmio
    import mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int DEB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    dmem_mmio_if.slave       bus,
    input  logic [3:0]       SW,
    output logic [9:0]       LEDR,
    output logic             TimerExpired
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    sel_e          sel;
    logic          we;
    logic [31:0]   wdata;
    logic [3:0]    sw_stable;

    logic [9:0]  led_q, led_d;
    logic [31:0] tload_q, tload_d;
    logic [31:0] count_q, count_d;
    logic        en_q, en_d, auto_q, auto_d, exp_q, exp_d;

    // Address bits outside [9:2] alias; fold them away explicitly.
    logic unused_addr;
    assign unused_addr = ^{bus.ALUOutMem[31:10], bus.ALUOutMem[1:0]};

    assign ram_idx = bus.ALUOutMem[2 +: AW];
    assign sel     = decode(bus.ALUOutMem[9:2]);
    assign we      = bus.MemWriteMem;
    assign wdata   = bus.WriteDataMem;

    sw_debounce #(.WIDTH(4), .DEB_CYCLES(DEB_CYCLES)) u_sw_debounce (
        .clk   (clk),
        .reset (reset),
        .sw_i  (SW),
        .sw_o  (sw_stable)
    );

    // RAM store port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we && sel == SEL_RAM) begin
            ram_q[ram_idx] <= wdata;
        end
    end

    // Register writes and timer step. Control bits written this cycle already
    // govern this cycle's timer step, so clearing EN on count==1 suppresses
    // the expiry, and an expiry beats a simultaneous write-1-to-clear.
    always_comb begin
        led_d   = led_q;
        tload_d = tload_q;
        count_d = count_q;
        en_d    = en_q;
        auto_d  = auto_q;
        exp_d   = exp_q;
        if (we && sel == SEL_LED) begin
            led_d = wdata[9:0];
        end
        if (we && sel == SEL_TLOAD) begin
            tload_d = wdata;
        end
        if (we && sel == SEL_TCTRL) begin
            en_d   = wdata[CTRL_EN];
            auto_d = wdata[CTRL_AUTO];
            if (wdata[CTRL_EXP]) begin
                exp_d = 1'b0;
            end
        end
        if (we && sel == SEL_TLOAD) begin
            count_d = wdata;
        end else if (en_d && count_q > 32'd1) begin
            count_d = count_q - 32'd1;
        end else if (en_d && count_q == 32'd1) begin
            exp_d   = 1'b1;
            count_d = auto_d ? tload_q : 32'd0;
        end
    end

    // LED and timer state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q   <= '0;
            tload_q <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            led_q   <= led_d;
            tload_q <= tload_d;
            count_q <= count_d;
            en_q    <= en_d;
            auto_q  <= auto_d;
            exp_q   <= exp_d;
        end
    end

    // Combinational load mux.
    always_comb begin
        bus.ReadDataMem = '0;
        unique case (sel)
            SEL_RAM:    bus.ReadDataMem = ram_q[ram_idx];
            SEL_LED:    bus.ReadDataMem = {22'd0, led_q};
            SEL_SW:     bus.ReadDataMem = {28'd0, sw_stable};
            SEL_TLOAD:  bus.ReadDataMem = tload_q;
            SEL_TCTRL: begin
                bus.ReadDataMem[CTRL_EN]   = en_q;
                bus.ReadDataMem[CTRL_AUTO] = auto_q;
                bus.ReadDataMem[CTRL_EXP]  = exp_q;
            end
            SEL_TCOUNT: bus.ReadDataMem = count_q;
            default:    bus.ReadDataMem = '0;
        endcase
    end

    assign LEDR         = led_q;
    assign TimerExpired = exp_q;

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory and memory-mapped I/O stage sitting directly downstream of the pipelined ARM core's Memory stage. It consumes the core's Mem-stage address, write data and write strobe, and returns `ReadDataMem` combinationally in the same cycle. Behind one address decoder it provides a 64-word data RAM, a 10-bit LED register, a debounced switch port and a 32-bit down-counting timer with sticky expiry. It replaces the plain data memory at the processor top level.

## Interface
- `RAM_WORDS`, 64: data RAM depth in 32-bit words. Must be a power of two, ≤ 64.
- `DEB_CYCLES`, 50000: consecutive stable cycles required before a switch change is accepted.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemWriteMem`  in  1  write strobe from the core's Mem stage.
- `ALUOutMem`  in  32  byte address from the core. Only `[9:2]` is decoded.
- `WriteDataMem`  in  32  store data.
- `ReadDataMem`  out  32  load data, combinational from the address and the current state.
- `SW`  in  4  raw, asynchronous board switches.
- `LEDR`  out  10  LED register contents.
- `TimerExpired`  out  1  sticky timer expiry flag.

## Operation
Address map. Bits `[31:10]` and `[1:0]` are ignored, so the map aliases every 1 KiB.
- 0x000–0x0FF: RAM, word index `ALUOutMem[7:2]`, read/write.
- 0x100 LED: read/write `[9:0]`. Reads return zero in the upper bits.
- 0x104 SW: read-only. Returns the debounced value in `[3:0]`.
- 0x108 TLOAD: read/write, 32 bits. A write also loads the counter.
- 0x10C TCTRL: read/write.
  - bit0 EN: read/write.
  - bit1 AUTO: read/write.
  - bit2 EXP: reads the sticky flag. Writing 1 clears it; writing 0 leaves it unchanged.
- 0x110 TCOUNT: read-only.
- Any other address reads 0x00000000. Writes to it are ignored.

Writes take effect at the rising edge while `MemWriteMem`=1. Writes to read-only registers are ignored.

Switch debounce:
- Two-flop synchronizer per bit.
- The counter clears whenever the synchronized value equals the stable value.
- Otherwise the counter increments. When it reaches `DEB_CYCLES`-1, the stable value takes the synchronized value and the counter clears.

Timer, evaluated each cycle:
- If TLOAD is written: count ← data. This has priority over decrementing.
- Else if EN=1 and count>1: count decrements.
- Else if EN=1 and count==1: EXP ← 1, and count ← (AUTO ? TLOAD : 0).
- With count==0 the counter holds and EXP is never set.

## Timing
- Reset (`reset`=0, asynchronous) clears LED, synchronizer flops, stable SW, debounce counter, TLOAD, count, EN, AUTO and EXP. All outputs read 0 during and after reset.
- RAM contents are not reset. Verification must write RAM before reading it.
- Load latency is 0 cycles (combinational). A read of an address in the same cycle it is written returns the old value; the new value is visible from the next cycle.
- Switch latency: a clean `SW` change appears at 0x104 exactly 2 + `DEB_CYCLES` cycles later. A glitch shorter than `DEB_CYCLES` cycles never appears.
- Timer: with EN=1 and TLOAD=N written at cycle t, count==0 first occurs at cycle t+N+1. EXP=1 is visible at that same cycle, and `TimerExpired` follows it.
- A write-1-to-clear of EXP in the same cycle as an expiry leaves EXP=1; set wins.
- If EN is cleared in the same cycle as count==1, no decrement occurs and no expiry occurs.
- Reset asserted mid-count aborts immediately. There is no pending expiry after release.

## Structure
- Package `mmio_pkg` holds:
  - address constants `ADDR_LED`, `ADDR_SW`, `ADDR_TLOAD`, `ADDR_TCTRL`, `ADDR_TCOUNT`;
  - TCTRL bit indices `CTRL_EN`, `CTRL_AUTO`, `CTRL_EXP`;
  - `RAM_TOP` = 0x0FF.
- Sub-module `sw_debounce`, parameterized by width and `DEB_CYCLES`, contains the synchronizer, the counter and the stable register. One instance is used, width 4.
- The RAM is an inferred array with asynchronous read. The decoder, LED register and timer stay in the top module.

## Test plan
- Reset, then write 0xDEADBEEF to 0x010 and 0x12345678 to 0x014, read both back.
  - Required: data matches, and the same-cycle read returned the old value.
  - A read of 0x410 returns 0xDEADBEEF (alias).
- Write 0xFFFFFFFF to 0x100: `LEDR`=0x3FF and a readback is 0x000003FF. A read of 0x1F0 returns 0; a write to 0x104 has no effect.
- With `DEB_CYCLES`=8, hold SW 0→0x5: 0x104 reads 0x5 at exactly cycle 10. A 5-cycle pulse to 0xF leaves the readback at 0x5.
- Write TLOAD=3, then TCTRL=0x1.
  - Required: count reads 3, 2, 1, 0 and EXP=1 at count 0; `TimerExpired`=1 holds.
  - Writing TCTRL=0x5 clears EXP while EN stays 1.
- Write TCTRL=0x3 with TLOAD=2: count cycles 2, 1, 2, 1, … and EXP sets on the first wrap. A same-cycle clear at the next expiry leaves EXP=1.
- Drop `reset` mid-count (count=0x80): all registers and outputs read 0 immediately. After release the count stays 0 and EXP stays 0.
